chacha20_decryption: RTL
========================

# chacha20_decryption

Block-level ChaCha20 decryptor. It accepts one 512-bit ciphertext block with its key, nonce and block counter, and generates the keystream using the full RFC 8439 block function (20 rounds, feed-forward add). It XORs the keystream with the ciphertext and returns the plaintext. It is the receive-side counterpart of the team's ChaCha20 encryption block, using the same word mapping so that encrypt→decrypt round-trips exactly. It uses valid/ready handshakes on both sides.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream has a block to decrypt
- in_ready  out  1  block idle and able to accept
- key  in  256  key; word k (k=0..7) = key[255-32k -: 32]
- nonce  in  96  nonce; words nonce[95:64], nonce[63:32], nonce[31:0]
- counter  in  32  block counter
- ciphertext  in  512  word i = ciphertext[i*32 +: 32], i=0..15
- out_valid  out  1  plaintext and out_counter valid
- out_ready  in  1  downstream accepts the result
- plaintext  out  512  word i = plaintext[i*32 +: 32]
- out_counter  out  32  counter of the block being presented
- busy  out  1  block accepted and not yet handed off (ROUND or OUTPUT)

## Operation
- **Initial state (words used directly, no byte swap):**
  - s0..s3 = 0x61707865, 0x3320646E, 0x79622D32, 0x6B206574
  - s4..s11 = key words 0..7
  - s12 = counter
  - s13..s15 = nonce[95:64], nonce[63:32], nonce[31:0]
- **Quarter round QR(a,b,c,d):** a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All additions are mod 2^32 with carries discarded. Rotations are left-rotate within 32 bits.
- **Even rounds (column):** QR(0,4,8,12), QR(1,5,9,13), QR(2,6,10,14), QR(3,7,11,15), all four in parallel in one cycle.
- **Odd rounds (diagonal):** QR(0,5,10,15), QR(1,6,11,12), QR(2,7,8,13), QR(3,4,9,14), in parallel in one cycle.
- **Output:** keystream word i = working[i] + initial[i] (mod 2^32). Plaintext word i = ciphertext word i XOR keystream word i.
- **Input capture:** key, nonce, counter and ciphertext are captured at acceptance. Input changes after acceptance have no effect on the block in flight.
- **FSM:**
  - IDLE: in_ready=1. On in_valid && in_ready, load the working and initial state, capture ciphertext and counter, set round_cnt=0, go to ROUND.
  - ROUND: apply round round_cnt (parity selects column/diagonal) and increment round_cnt. In the cycle with round_cnt==19, register plaintext and out_counter, set out_valid=1, go to OUTPUT.
  - OUTPUT: hold plaintext, out_counter and out_valid stable. On out_valid && out_ready, clear out_valid, set in_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. A new block is never accepted in the same cycle the result is handed off.
- Counter 0xFFFFFFFF is used as-is. There is no carry into the nonce and no internal counter increment.

## Timing
- **Reset values:** in_ready=0, out_valid=0, busy=0, plaintext=0, out_counter=0, FSM=IDLE, round_cnt=0.
- in_ready rises at the first rising edge after reset deasserts.
- **Latency:** acceptance at edge E0. Rounds execute at E1..E20. out_valid and plaintext are registered at E20 and visible after E20.
- **Throughput:** with out_ready held high, handoff occurs at E21, in_ready is high after E21, and the next acceptance is at E22. That is one block per 22 cycles.
- in_ready, out_valid and busy are registered; there is no combinational path from in_valid or out_ready to any output.
- **Reset asserted mid-operation:** takes effect immediately and asynchronously. The in-flight block is discarded, all outputs return to reset values, and no out_valid is produced for it.
- **Back-pressure:** out_ready may stay low indefinitely. Outputs stay bit-stable and in_ready stays 0 for the whole wait.

## Test plan
- **RFC 8439 §2.3.2 keystream:**
  - Stimulus: key bytes 00..1f, giving key word0 = 0x03020100 … word7 = 0x1f1e1d1c; counter = 1; nonce words 0x09000000, 0x4A000000, 0x00000000; ciphertext = 0.
  - Required response: plaintext word0 = 0xE4E7F110, remaining words equal to the RFC serialized block; out_valid rises 20 cycles after acceptance.
- **Round-trip:**
  - Stimulus: random key, nonce, counter and 512-bit plaintext P; ciphertext C = P XOR reference-model keystream.
  - Required response: plaintext output = P exactly and out_counter = counter. Repeat for 1000 random vectors.
- **Back-pressure and ignored input:**
  - Stimulus: out_ready low for 10 cycles after out_valid rises, while new in_valid pulses are driven.
  - Required response: output is stable, in_ready stays 0, and nothing extra is accepted. After out_ready goes high, in_ready rises next cycle and exactly one block is output.
- **Back-to-back streaming:**
  - Stimulus: 4 blocks with counters 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 and out_ready held high.
  - Required response: 22-cycle spacing between acceptances, correct plaintext for each block, and out_counter echoes the inputs with no nonce change.
- **Reset mid-round:**
  - Stimulus: assert reset at round 7 for 2 cycles.
  - Required response: outputs go to reset values immediately, no out_valid for the aborted block, and the next block decrypts correctly.
- **Input capture:**
  - Stimulus: change key, nonce and ciphertext every cycle after acceptance.
  - Required response: result matches the values captured at acceptance.

Source files
------------

// File: rtl/chacha20_decryption_if.sv
// Handshake bundle for the ChaCha20 block decryptor.
// The upstream/downstream side uses master and the decryptor uses slave.
interface chacha20_decryption_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic [511:0] ciphertext;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] plaintext;
    logic [31:0]  out_counter;
    logic         busy;

    modport master (
        output in_valid, key, nonce, counter, ciphertext, out_ready,
        input  in_ready, out_valid, plaintext, out_counter, busy
    );

    modport slave (
        input  in_valid, key, nonce, counter, ciphertext, out_ready,
        output in_ready, out_valid, plaintext, out_counter, busy
    );
endinterface

// File: rtl/chacha20_decryption.sv
// ChaCha20 block decryptor: one double-round half per cycle (20 cycles),
// feed-forward add, XOR with the captured ciphertext, valid/ready on both sides.
module chacha20_qr (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d
);
    logic [31:0] w_a1, w_b1, w_c1, w_d1, w_dx1, w_bx1, w_dx2, w_bx2;

    assign w_a1  = i_a + i_b;
    assign w_dx1 = i_d ^ w_a1;
    assign w_d1  = {w_dx1[15:0], w_dx1[31:16]};
    assign w_c1  = i_c + w_d1;
    assign w_bx1 = i_b ^ w_c1;
    assign w_b1  = {w_bx1[19:0], w_bx1[31:20]};
    assign o_a   = w_a1 + w_b1;
    assign w_dx2 = w_d1 ^ o_a;
    assign o_d   = {w_dx2[23:0], w_dx2[31:24]};
    assign o_c   = w_c1 + o_d;
    assign w_bx2 = w_b1 ^ o_c;
    assign o_b   = {w_bx2[24:0], w_bx2[31:25]};
endmodule

module chacha20_decryption (
    input  logic                   clk,
    input  logic                   reset,
    chacha20_decryption_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_OUTPUT} state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0][31:0] r_work, r_init, w_init_ld, w_sh, w_col, w_round, w_ks;
    logic [511:0]      r_ct, r_pt;
    logic [31:0]       r_ctr, r_out_ctr;
    logic [4:0]        r_round_cnt;
    logic              r_in_ready, r_out_valid, r_busy;
    logic              w_accept, w_handoff, w_last, w_odd;
    logic              w_in_ready_nxt, w_out_valid_nxt, w_busy_nxt;

    always_comb begin
        w_init_ld[0] = 32'h61707865;
        w_init_ld[1] = 32'h3320646E;
        w_init_ld[2] = 32'h79622D32;
        w_init_ld[3] = 32'h6B206574;
        for (int k = 0; k < 8; k++) w_init_ld[4+k] = bus.key[255-32*k -: 32];
        w_init_ld[12] = bus.counter;
        w_init_ld[13] = bus.nonce[95:64];
        w_init_ld[14] = bus.nonce[63:32];
        w_init_ld[15] = bus.nonce[31:0];
    end

    // Diagonal rounds reuse the column datapath: rotate row r left by r
    // before the quarter rounds and back afterwards.
    assign w_odd = r_round_cnt[0];

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar g = 0; g < 4; g++) begin : g_col
            localparam int SH = 4*r + ((g + r) % 4);
            localparam int UN = 4*r + ((g - r + 4) % 4);
            assign w_sh[4*r+g]    = w_odd ? r_work[SH] : r_work[4*r+g];
            assign w_round[4*r+g] = w_odd ? w_col[UN]  : w_col[4*r+g];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        chacha20_qr u_qr (
            .i_a(w_sh[g]),   .i_b(w_sh[4+g]),  .i_c(w_sh[8+g]),  .i_d(w_sh[12+g]),
            .o_a(w_col[g]),  .o_b(w_col[4+g]), .o_c(w_col[8+g]), .o_d(w_col[12+g])
        );
    end

    for (genvar i = 0; i < 16; i++) begin : g_ks
        assign w_ks[i] = w_round[i] + r_init[i];
    end

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid && r_in_ready;
    assign w_handoff = (r_state == S_OUTPUT) && r_out_valid && bus.out_ready;
    assign w_last    = (r_state == S_ROUND) && (r_round_cnt == 5'd19);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)  w_state_nxt = S_ROUND;
            S_ROUND:  if (w_last)    w_state_nxt = S_OUTPUT;
            S_OUTPUT: if (w_handoff) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered copies of where the FSM is heading.
    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_OUTPUT);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work      <= '0;
            r_init      <= '0;
            r_ct        <= '0;
            r_ctr       <= '0;
            r_round_cnt <= '0;
            r_pt        <= '0;
            r_out_ctr   <= '0;
        end else begin
            if (w_accept) begin
                r_work      <= w_init_ld;
                r_init      <= w_init_ld;
                r_ct        <= bus.ciphertext;
                r_ctr       <= bus.counter;
                r_round_cnt <= '0;
            end else if (r_state == S_ROUND) begin
                r_work      <= w_round;
                r_round_cnt <= w_last ? 5'd0 : r_round_cnt + 5'd1;
            end
            if (w_last) begin
                r_pt      <= r_ct ^ w_ks;
                r_out_ctr <= r_ctr;
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.plaintext   = r_pt;
    assign bus.out_counter = r_out_ctr;
endmodule
